alsu_sequencer: RTL and testbench

Command-side driver for the registered ALSU. It accepts one operation per command over a valid/ready handshake, drives the ALSU control inputs for the required number of cycles, and supplies `serial_in` bit by bit for shift operations. It then collects the registered ALSU result and the LED error indication and returns them as a single response over a valid/ready handshake. It sits between a host/test controller and the ALSU and is the only agent driving ALSU inputs.

---
 rtl/alsu_sequencer_if.sv | 54 +++++
 rtl/alsu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alsu_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_sequencer_if.sv
// Bundle of every handshake/bus signal around the ALSU sequencer.
//   cmd_*  : host -> sequencer command channel (valid/ready)
//   rsp_*  : sequencer -> host response channel (valid/ready)
//   alsu_* : sequencer -> ALSU control inputs, ALSU -> sequencer registered outputs
// Modports:
//   slave  : the sequencer itself
//   master : the environment (host side plus the ALSU)
interface alsu_sequencer_if #(
  parameter int REPEAT_W = 3
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [2:0]               cmd_opcode;
  logic [2:0]               cmd_a;
  logic [2:0]               cmd_b;
  logic [5:0]               cmd_flags;
  logic [REPEAT_W-1:0]      cmd_repeat;
  logic                     cmd_preload;
  logic [2**REPEAT_W-1:0]   cmd_serial;

  logic [2:0]               alsu_A;
  logic [2:0]               alsu_B;
  logic [2:0]               alsu_opcode;
  logic                     alsu_red_op_A;
  logic                     alsu_red_op_B;
  logic                     alsu_bypass_A;
  logic                     alsu_bypass_B;
  logic                     alsu_direction;
  logic                     alsu_cin;
  logic                     alsu_serial_in;
  logic [5:0]               alsu_out;
  logic [15:0]              alsu_leds;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [5:0]               rsp_out;
  logic                     rsp_error;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_flags, cmd_repeat,
           cmd_preload, cmd_serial, alsu_out, alsu_leds, rsp_ready,
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_red_op_A,
           alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction,
           alsu_cin, alsu_serial_in, rsp_valid, rsp_out, rsp_error
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_flags, cmd_repeat,
           cmd_preload, cmd_serial, alsu_out, alsu_leds, rsp_ready,
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_red_op_A,
           alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction,
           alsu_cin, alsu_serial_in, rsp_valid, rsp_out, rsp_error
  );
endinterface

// File: rtl/alsu_sequencer.sv
// Command-side driver for the registered ALSU.
// Accepts one command, optionally preloads the ALSU output with cmd_a, issues
// the operation R+1 cycles (feeding serial_in one bit per cycle), collects the
// result and a sticky LED error flag, and returns them as one response.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alsu_sequencer_if.slave (command, response and ALSU signals)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cmd_ready high, ALSU driven idle, waiting for a command
// S_ISSUE | optional preload cycle, then R+1 op cycles
// S_WAIT  | ALSU result of last op cycle is registered; capture it
// S_RESP  | rsp_valid high, response held until rsp_ready
module alsu_sequencer #(
  parameter int REPEAT_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alsu_sequencer_if.slave bus
);
  localparam int SER_W = 2**REPEAT_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;

  logic [2:0]          opcode_q, a_q, b_q;
  logic [5:0]          flags_q;
  logic [SER_W-1:0]    ser_q;
  logic [REPEAT_W-1:0] cnt_q;
  logic                pre_q;
  logic                err_q;
  logic [5:0]          out_q;
  logic                ready_q;
  logic                op_prev_q;

  logic                cmd_hs;
  logic                op_cycle;

  logic [2:0]          drv_A, drv_B, drv_opcode;
  logic [5:0]          drv_flags;
  logic                drv_serial;

  assign cmd_hs   = (state == S_IDLE) && bus.cmd_valid && ready_q;
  assign op_cycle = (state == S_ISSUE) && !pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and ALSU drive. Anything other than an ISSUE cycle drives the
  // ALSU idle (AND of zeros), which also clears its output and LEDs.
  always_comb begin
    state_nxt  = state;
    drv_A      = 3'd0;
    drv_B      = 3'd0;
    drv_opcode = 3'd0;
    drv_flags  = 6'd0;
    drv_serial = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_hs) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (pre_q) begin
          drv_A        = a_q;
          drv_flags[3] = 1'b1;
        end else begin
          drv_A      = a_q;
          drv_B      = b_q;
          drv_opcode = opcode_q;
          drv_flags  = flags_q;
          drv_serial = ser_q[0];
          if (cnt_q == '0) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= 3'd0;
      a_q       <= 3'd0;
      b_q       <= 3'd0;
      flags_q   <= 6'd0;
      ser_q     <= '0;
      cnt_q     <= '0;
      pre_q     <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= 6'd0;
      ready_q   <= 1'b0;
      op_prev_q <= 1'b0;
    end else begin
      ready_q   <= ((state == S_IDLE) && !cmd_hs) ||
                   ((state == S_RESP) && bus.rsp_ready);
      op_prev_q <= op_cycle;

      if (cmd_hs) begin
        opcode_q <= bus.cmd_opcode;
        a_q      <= bus.cmd_a;
        b_q      <= bus.cmd_b;
        flags_q  <= bus.cmd_flags;
        ser_q    <= bus.cmd_serial;
        cnt_q    <= bus.cmd_repeat;
        pre_q    <= bus.cmd_preload;
        err_q    <= 1'b0;
      end else if (op_prev_q && (bus.alsu_leds != 16'd0)) begin
        // LEDs toggle on back-to-back invalid cycles, so keep the flag sticky.
        err_q <= 1'b1;
      end

      if (state == S_ISSUE) begin
        if (pre_q) begin
          pre_q <= 1'b0;
        end else begin
          // Serial bits are consumed LSB first; counter stops at terminal 0.
          ser_q <= ser_q >> 1;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
      end

      if (state == S_WAIT) out_q <= bus.alsu_out;
    end
  end

  assign bus.cmd_ready      = ready_q;
  assign bus.rsp_valid      = (state == S_RESP);
  assign bus.rsp_out        = out_q;
  assign bus.rsp_error      = err_q;

  assign bus.alsu_A         = drv_A;
  assign bus.alsu_B         = drv_B;
  assign bus.alsu_opcode    = drv_opcode;
  assign bus.alsu_red_op_A  = drv_flags[5];
  assign bus.alsu_red_op_B  = drv_flags[4];
  assign bus.alsu_bypass_A  = drv_flags[3];
  assign bus.alsu_bypass_B  = drv_flags[2];
  assign bus.alsu_direction = drv_flags[1];
  assign bus.alsu_cin       = drv_flags[0];
  assign bus.alsu_serial_in = drv_serial;
endmodule

// File: tb/tb_alsu_sequencer.sv
module tb_alsu_sequencer;
  localparam int REPEAT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alsu_sequencer_if #(.REPEAT_W(REPEAT_W)) bus ();

  alsu_sequencer #(.REPEAT_W(REPEAT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] opc;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] fl;
    logic [2:0] rep;
    logic       pre;
    logic [7:0] ser;
  } cmd_t;

  typedef struct {
    cmd_t       c;
    logic [5:0] e_out;
    logic       e_err;
    int         e_lat;
  } vec_t;

  // Behavioural registered ALSU: returns {out, leds} after one clock.
  function automatic logic [21:0] alsu_f(input logic [5:0] o, input logic [15:0] l,
                                         input logic [2:0] opc, input logic [2:0] a,
                                         input logic [2:0] b, input logic [5:0] fl,
                                         input logic sin);
    logic invalid;
    logic [5:0] no;
    logic [15:0] nl;
    logic [5:0] ea, eb;
    ea = {3'b000, a};
    eb = {3'b000, b};
    invalid = (opc[2:1] == 2'b11) || ((fl[5] || fl[4]) && (opc[2:1] != 2'b00));
    nl = invalid ? ~l : 16'h0000;
    if (fl[3])       no = ea;
    else if (fl[2])  no = eb;
    else if (invalid) no = 6'd0;
    else begin
      case (opc)
        3'b000:  no = fl[5] ? {5'd0, &a} : fl[4] ? {5'd0, &b} : (ea & eb);
        3'b001:  no = fl[5] ? {5'd0, ^a} : fl[4] ? {5'd0, ^b} : (ea ^ eb);
        3'b010:  no = ea + eb + {5'd0, fl[0]};
        3'b011:  no = ea * eb;
        3'b100:  no = fl[1] ? {o[4:0], sin} : {sin, o[5:1]};
        default: no = fl[1] ? {o[4:0], o[5]} : {o[0], o[5:1]};
      endcase
    end
    return {no, nl};
  endfunction

  logic [21:0] alsu_nxt;
  assign alsu_nxt = alsu_f(bus.alsu_out, bus.alsu_leds, bus.alsu_opcode, bus.alsu_A, bus.alsu_B,
                           {bus.alsu_red_op_A, bus.alsu_red_op_B, bus.alsu_bypass_A,
                            bus.alsu_bypass_B, bus.alsu_direction, bus.alsu_cin},
                           bus.alsu_serial_in);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alsu_out  <= 6'd0;
      bus.alsu_leds <= 16'd0;
    end else begin
      bus.alsu_out  <= alsu_nxt[21:16];
      bus.alsu_leds <= alsu_nxt[15:0];
    end
  end

  // Command-level reference: ALSU starts at 0 (or cmd_a when preloaded), then
  // the operation is applied R+1 times; error is any nonzero LED word seen.
  task automatic ref_cmd(input cmd_t c, output logic [5:0] o, output logic e);
    logic [21:0] r;
    logic [15:0] l;
    o = c.pre ? {3'b000, c.a} : 6'd0;
    l = 16'd0;
    e = 1'b0;
    for (int i = 0; i <= int'(c.rep); i++) begin
      r = alsu_f(o, l, c.opc, c.a, c.b, c.fl, c.ser[i]);
      o = r[21:16];
      l = r[15:0];
      if (l != 16'd0) e = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int alsu_drive();
    return int'({bus.alsu_A, bus.alsu_B, bus.alsu_opcode, bus.alsu_red_op_A, bus.alsu_red_op_B,
                 bus.alsu_bypass_A, bus.alsu_bypass_B, bus.alsu_direction, bus.alsu_cin,
                 bus.alsu_serial_in});
  endfunction

  task automatic send_cmd(input cmd_t c);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) chk("cmd_ready_timeout", int'(bus.cmd_ready), 1);
    bus.cmd_opcode  = c.opc;
    bus.cmd_a       = c.a;
    bus.cmd_b       = c.b;
    bus.cmd_flags   = c.fl;
    bus.cmd_repeat  = c.rep;
    bus.cmd_preload = c.pre;
    bus.cmd_serial  = c.ser;
    bus.cmd_valid   = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack_rsp(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    cmd_t c;
    int lat, n, cnt;
    logic [5:0] e_out;
    logic e_err;

    vecs[0] = '{'{3'b010, 3'd5, 3'd6, 6'b000001, 3'd0, 1'b0, 8'h00}, 6'd12, 1'b0, 2};
    vecs[1] = '{'{3'b011, 3'd7, 3'd7, 6'b000000, 3'd0, 1'b0, 8'h00}, 6'd49, 1'b0, 2};
    vecs[2] = '{'{3'b101, 3'd5, 3'd0, 6'b000010, 3'd2, 1'b1, 8'h00}, 6'd40, 1'b0, 5};
    vecs[3] = '{'{3'b100, 3'd0, 3'd0, 6'b000000, 3'd2, 1'b0, 8'h07}, 6'd56, 1'b0, 4};
    vecs[4] = '{'{3'b110, 3'd3, 3'd4, 6'b000000, 3'd0, 1'b0, 8'h00}, 6'd0,  1'b1, 2};
    vecs[5] = '{'{3'b010, 3'd1, 3'd1, 6'b100000, 3'd1, 1'b0, 8'h00}, 6'd0,  1'b1, 3};
    vecs[6] = '{'{3'b001, 3'd2, 3'd7, 6'b010000, 3'd0, 1'b0, 8'h00}, 6'd1,  1'b0, 2};
    vecs[7] = '{'{3'b100, 3'd0, 3'd0, 6'b000010, 3'd7, 1'b0, 8'hB3}, 6'd13, 1'b0, 9};
    vecs[8] = '{'{3'b111, 3'd6, 3'd6, 6'b000000, 3'd1, 1'b0, 8'h00}, 6'd0,  1'b1, 3};
    vecs[9] = '{'{3'b010, 3'd3, 3'd2, 6'b000000, 3'd0, 1'b1, 8'h00}, 6'd5,  1'b0, 3};

    bus.cmd_valid = 1'b0; bus.cmd_opcode = 3'd0; bus.cmd_a = 3'd0; bus.cmd_b = 3'd0;
    bus.cmd_flags = 6'd0; bus.cmd_repeat = 3'd0; bus.cmd_preload = 1'b0;
    bus.cmd_serial = 8'd0; bus.rsp_ready = 1'b0;

    #12;
    chk("reset_cmd_ready", int'(bus.cmd_ready), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_out",   int'(bus.rsp_out), 0);
    chk("reset_rsp_error", int'(bus.rsp_error), 0);
    chk("reset_alsu_drive", alsu_drive(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", int'(bus.cmd_ready), 1);

    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].c);
      wait_rsp(lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].e_lat);
      chk($sformatf("vec%0d_rsp_out", i), int'(bus.rsp_out), int'(vecs[i].e_out));
      chk($sformatf("vec%0d_rsp_error", i), int'(bus.rsp_error), int'(vecs[i].e_err));
      ack_rsp(0);
      chk($sformatf("vec%0d_ready_after_rsp", i), int'(bus.cmd_ready), 1);
      chk($sformatf("vec%0d_valid_after_rsp", i), int'(bus.rsp_valid), 0);
    end

    // Backpressure: response held stable, stray commands ignored.
    c = '{3'b010, 3'd2, 3'd3, 6'b000000, 3'd0, 1'b0, 8'h00};
    send_cmd(c);
    wait_rsp(lat);
    chk("bp_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      bus.cmd_opcode = 3'b011; bus.cmd_a = 3'd7; bus.cmd_b = 3'd7;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
      chk("bp_rsp_out", int'(bus.rsp_out), 5);
      chk("bp_rsp_error", int'(bus.rsp_error), 0);
      chk("bp_cmd_ready", int'(bus.cmd_ready), 0);
      chk("bp_alsu_idle", alsu_drive(), 0);
    end
    bus.cmd_valid = 1'b0;
    ack_rsp(0);
    chk("bp_ready_after_rsp", int'(bus.cmd_ready), 1);
    chk("bp_valid_after_rsp", int'(bus.rsp_valid), 0);

    // Throughput with rsp_ready held high: P=1, R=2 -> one command per 7 cycles.
    bus.rsp_ready = 1'b1;
    c = '{3'b101, 3'd5, 3'd0, 6'b000010, 3'd2, 1'b1, 8'h00};
    send_cmd(c);
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("throughput_cycles", n + 1, 7);
    bus.rsp_ready = 1'b0;
    chk("throughput_rsp_out", int'(bus.rsp_out), 40);

    // Reset in the middle of ISSUE.
    c = '{3'b011, 3'd7, 3'd7, 6'b000000, 3'd5, 1'b0, 8'h00};
    send_cmd(c);
    @(posedge clk); #1;
    chk("mid_issue_opcode", int'(bus.alsu_opcode), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alsu_idle", alsu_drive(), 0);
    chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 0);
    chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("mid_rst_rsp_out",   int'(bus.rsp_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", int'(bus.cmd_ready), 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) cnt++;
    end
    chk("post_rst_no_response", cnt, 0);

    // Randomized commands against the command-level reference.
    for (int i = 0; i < 150; i++) begin
      c.opc = 3'($urandom_range(0, 7));
      c.a   = 3'($urandom_range(0, 7));
      c.b   = 3'($urandom_range(0, 7));
      c.fl  = 6'($urandom);
      if ($urandom_range(0, 1) == 0) c.fl[5:2] = 4'b0000;
      c.rep = 3'($urandom_range(0, 7));
      c.pre = 1'($urandom_range(0, 1));
      c.ser = 8'($urandom);
      ref_cmd(c, e_out, e_err);
      send_cmd(c);
      wait_rsp(lat);
      chk($sformatf("rnd%0d_latency", i), lat, int'(c.pre) + int'(c.rep) + 2);
      chk($sformatf("rnd%0d_rsp_out", i), int'(bus.rsp_out), int'(e_out));
      chk($sformatf("rnd%0d_rsp_error", i), int'(bus.rsp_error), int'(e_err));
      ack_rsp($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
